// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: IDCODE layout and value, data-register capture-mode encodings.
package jtag_pkg;

    localparam int unsigned JTAG_VERSION_W = 4;
    localparam int unsigned JTAG_PART_W    = 16;
    localparam int unsigned JTAG_MANUF_W   = 11;
    localparam int unsigned JTAG_FIXED_W   = 1;
    localparam int unsigned JTAG_IDCODE_W  = JTAG_VERSION_W + JTAG_PART_W + JTAG_MANUF_W + JTAG_FIXED_W;

    typedef struct packed {
        logic [JTAG_VERSION_W-1:0] version;
        logic [JTAG_PART_W-1:0]    part;
        logic [JTAG_MANUF_W-1:0]   manuf;
        logic [JTAG_FIXED_W-1:0]   fixed_one;
    } jtag_idcode_t;

    // Bit 0 is always 1 so a debugger can tell IDCODE from BYPASS.
    localparam jtag_idcode_t JTAG_IDCODE_FIELDS = '{
        version:   4'h1,
        part:      16'h5A3C,
        manuf:     11'h49F,
        fixed_one: 1'b1
    };
    localparam logic [JTAG_IDCODE_W-1:0] JTAG_IDCODE = JTAG_IDCODE_FIELDS;

    localparam int unsigned JTAG_CAP_CONST    = 0;
    localparam int unsigned JTAG_CAP_PARALLEL = 1;

    // Shift counter must reach WIDTH+1 so an over-length shift is distinguishable.
    function automatic int unsigned jtag_cnt_w(input int unsigned width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/jtag_dr_cell.sv
// One bit of a JTAG data register: capture/shift flop feeding a parallel update flop.
module jtag_dr_cell #(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic tck,
    input  logic trst_n,
    input  logic cap,
    input  logic sh,
    input  logic up,
    input  logic cap_bit,
    input  logic shift_in,
    output logic sr_bit,
    output logic upd_bit
);

    // Capture has priority over shift; the top already makes them exclusive.
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            sr_bit <= RESET_BIT;
        end else if (cap) begin
            sr_bit <= cap_bit;
        end else if (sh) begin
            sr_bit <= shift_in;
        end
    end

    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            upd_bit <= RESET_BIT;
        end else if (up) begin
            upd_bit <= sr_bit;
        end
    end

endmodule

// File: rtl/jtag_dr.sv
// Parametrised JTAG data register (capture/shift/update) built from jtag_dr_cell bits.
// Optional shift-length check enabled by defining JTAG_DR_LEN_CHECK_EN.
module jtag_dr
    import jtag_pkg::*;
#(
    parameter int unsigned       WIDTH         = 32,
    parameter int unsigned       CAPTURE_MODE  = JTAG_CAP_CONST,
    parameter logic [WIDTH-1:0]  CAPTURE_VALUE = WIDTH'(JTAG_IDCODE),
    parameter logic [WIDTH-1:0]  RESET_VALUE   = '0
) (
    input  logic             tck,
    input  logic             trst_n,
    input  logic             select,
    input  logic             captureDR,
    input  logic             shiftDR,
    input  logic             updateDR,
    input  logic             tdi,
    input  logic [WIDTH-1:0] capture_data,
    output logic             tdo,
    output logic [WIDTH-1:0] update_data,
    output logic             update_strobe,
    output logic             len_error
);

    logic             cap;
    logic             sh;
    logic             up_req;
    logic             up_ok;
    logic             len_ok;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] cap_vec;
    logic [WIDTH-1:0] shift_in;

    // Exclusive strobes: capture beats shift beats update.
    assign cap    = select & captureDR;
    assign sh     = select & shiftDR & ~captureDR;
    assign up_req = select & updateDR & ~captureDR & ~shiftDR;
    assign up_ok  = up_req & len_ok;

    assign cap_vec = (CAPTURE_MODE == JTAG_CAP_PARALLEL) ? capture_data : CAPTURE_VALUE;
    assign tdo     = sr[0];

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        if (i == int'(WIDTH) - 1) begin : g_msb
            assign shift_in[i] = tdi;
        end else begin : g_mid
            assign shift_in[i] = sr[i+1];
        end

        jtag_dr_cell #(
            .RESET_BIT (RESET_VALUE[i])
        ) u_cell (
            .tck      (tck),
            .trst_n   (trst_n),
            .cap      (cap),
            .sh       (sh),
            .up       (up_ok),
            .cap_bit  (cap_vec[i]),
            .shift_in (shift_in[i]),
            .sr_bit   (sr[i]),
            .upd_bit  (update_data[i])
        );
    end

    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            update_strobe <= 1'b0;
        end else begin
            update_strobe <= up_ok;
        end
    end

`ifdef JTAG_DR_LEN_CHECK_EN
    localparam int unsigned CNT_W = jtag_cnt_w(WIDTH);

    logic [CNT_W-1:0] cnt;

    // Counts shifts since the last capture, saturating one past WIDTH.
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            cnt <= '0;
        end else if (cap) begin
            cnt <= '0;
        end else if (sh && (cnt != CNT_W'(WIDTH + 1))) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign len_ok = (cnt == CNT_W'(WIDTH));

    // Sticky until an update is accepted.
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            len_error <= 1'b0;
        end else if (up_req) begin
            len_error <= ~len_ok;
        end
    end
`else
    assign len_ok    = 1'b1;
    assign len_error = 1'b0;
`endif

endmodule

// File: tb/tb_jtag_dr.sv
// Self-checking bench for jtag_dr: directed table, corner sequences and random vs. a reference model.
module tb_jtag_dr;
    import jtag_pkg::*;

`ifdef JTAG_DR_LEN_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    localparam logic [31:0] ID_VAL = 32'h1234_5679;
    localparam logic [7:0]  RV_B   = 8'h81;

    logic        tck;
    logic        trst_n;
    logic        sel_a, sel_b;
    logic        cap_i, sh_i, up_i, tdi_i;
    logic [31:0] cd_a;
    logic [7:0]  cd_b;
    logic        tdo_a, us_a, le_a;
    logic [31:0] ud_a;
    logic        tdo_b, us_b, le_b;
    logic [7:0]  ud_b;

    int n_cmp = 0;
    int n_err = 0;

    jtag_dr #(
        .WIDTH         (32),
        .CAPTURE_MODE  (JTAG_CAP_CONST),
        .CAPTURE_VALUE (ID_VAL),
        .RESET_VALUE   (32'h0)
    ) u_dut_id (
        .tck           (tck),
        .trst_n        (trst_n),
        .select        (sel_a),
        .captureDR     (cap_i),
        .shiftDR       (sh_i),
        .updateDR      (up_i),
        .tdi           (tdi_i),
        .capture_data  (cd_a),
        .tdo           (tdo_a),
        .update_data   (ud_a),
        .update_strobe (us_a),
        .len_error     (le_a)
    );

    jtag_dr #(
        .WIDTH         (8),
        .CAPTURE_MODE  (JTAG_CAP_PARALLEL),
        .CAPTURE_VALUE (8'h00),
        .RESET_VALUE   (RV_B)
    ) u_dut_dr (
        .tck           (tck),
        .trst_n        (trst_n),
        .select        (sel_b),
        .captureDR     (cap_i),
        .shiftDR       (sh_i),
        .updateDR      (up_i),
        .tdi           (tdi_i),
        .capture_data  (cd_b),
        .tdo           (tdo_b),
        .update_data   (ud_b),
        .update_strobe (us_b),
        .len_error     (le_b)
    );

    initial tck = 1'b0;
    always #5 tck = ~tck;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: index 0 = 32-bit ID register, index 1 = 8-bit parallel register.
    logic [63:0] m_sr  [2];
    logic [63:0] m_ud  [2];
    bit          m_us  [2];
    bit          m_le  [2];
    int          m_cnt [2];
    int          m_w   [2] = '{32, 8};
    logic [63:0] m_rv  [2] = '{64'h0, 64'(RV_B)};

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_sr[k]  = m_rv[k];
            m_ud[k]  = m_rv[k];
            m_us[k]  = 1'b0;
            m_le[k]  = 1'b0;
            m_cnt[k] = 0;
        end
    endtask

    task automatic model_edge(input int k, input bit sel, input logic [63:0] capv);
        logic [63:0] mask;
        mask = (64'h1 << m_w[k]) - 64'h1;
        m_us[k] = 1'b0;
        if (sel && cap_i) begin
            m_sr[k]  = capv & mask;
            m_cnt[k] = 0;
        end else if (sel && sh_i) begin
            m_sr[k]  = ((m_sr[k] >> 1) | (64'(tdi_i) << (m_w[k] - 1))) & mask;
            m_cnt[k] = (m_cnt[k] < m_w[k] + 1) ? m_cnt[k] + 1 : m_cnt[k];
        end else if (sel && up_i) begin
            if (!CHK || m_cnt[k] == m_w[k]) begin
                m_ud[k] = m_sr[k];
                m_us[k] = 1'b1;
                m_le[k] = 1'b0;
            end else begin
                m_le[k] = 1'b1;
            end
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("a.tdo", 64'(tdo_a), 64'(m_sr[0][0]));
        chk("a.update_data", 64'(ud_a), m_ud[0]);
        chk("a.update_strobe", 64'(us_a), 64'(m_us[0]));
        chk("a.len_error", 64'(le_a), 64'(m_le[0]));
        chk("b.tdo", 64'(tdo_b), 64'(m_sr[1][0]));
        chk("b.update_data", 64'(ud_b), m_ud[1]);
        chk("b.update_strobe", 64'(us_b), 64'(m_us[1]));
        chk("b.len_error", 64'(le_b), 64'(m_le[1]));
    endtask

    task automatic step(input bit sa, input bit sb, input bit c, input bit s, input bit u,
                        input bit t, input logic [31:0] ca, input logic [7:0] cb);
        @(negedge tck);
        sel_a = sa; sel_b = sb; cap_i = c; sh_i = s; up_i = u; tdi_i = t;
        cd_a = ca; cd_b = cb;
        @(posedge tck);
        model_edge(0, sa, 64'(ID_VAL));
        model_edge(1, sb, 64'(cb));
        #1;
        compare_model();
    endtask

    typedef struct {
        bit         sel, cap, sh, up, tdi;
        logic [7:0] cd;
        bit         e_tdo;
        logic [7:0] e_ud;
        bit         e_us, e_le;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit sel, bit cap, bit sh, bit up, bit tdi, logic [7:0] cd,
                                bit e_tdo, logic [7:0] e_ud, bit e_us, bit e_le);
        vec_t v;
        v.sel = sel; v.cap = cap; v.sh = sh; v.up = up; v.tdi = tdi; v.cd = cd;
        v.e_tdo = e_tdo; v.e_ud = e_ud; v.e_us = e_us; v.e_le = e_le;
        return v;
    endfunction

    initial begin
        logic [7:0]  ud_short;
        logic [31:0] id_seen;
        bit          tdo_rows [8] = '{0, 1, 0, 0, 1, 0, 1, 0};
        bit          tdi_rows [8] = '{0, 0, 1, 1, 1, 1, 0, 0};

        ud_short = CHK ? 8'h3C : 8'hFE;

        // Capture A5, shift in 3C LSB-first, update.
        tbl.push_back(mk(1, 1, 0, 0, 0, 8'hA5, 1, RV_B, 0, 0));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(1, 0, 1, 0, tdi_rows[i], 8'h00, tdo_rows[i], RV_B, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 8'h00, 0, 8'h3C, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 8'h00, 0, 8'h3C, 0, 0));
        // Short shift (7 bits) then update.
        tbl.push_back(mk(1, 1, 0, 0, 0, 8'h00, 0, 8'h3C, 0, 0));
        for (int i = 0; i < 7; i++)
            tbl.push_back(mk(1, 0, 1, 0, 1, 8'h00, 0, 8'h3C, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 8'h00, 0, ud_short, !CHK, CHK));
        // Full shift of FF then two consecutive updates.
        tbl.push_back(mk(1, 1, 0, 0, 0, 8'h00, 0, ud_short, 0, CHK));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(1, 0, 1, 0, 1, 8'h00, (i == 7), ud_short, 0, CHK));
        tbl.push_back(mk(1, 0, 0, 1, 0, 8'h00, 1, 8'hFF, 1, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 8'h00, 1, 8'hFF, 1, 0));
        // Deselected strobes change nothing.
        tbl.push_back(mk(0, 1, 0, 0, 0, 8'h00, 1, 8'hFF, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 8'h00, 1, 8'hFF, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'h00, 1, 8'hFF, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 0, 8'h00, 1, 8'hFF, 0, 0));
        // Capture and shift together: capture wins.
        tbl.push_back(mk(1, 1, 1, 0, 1, 8'h5A, 0, 8'hFF, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 8'h00, 0, CHK ? 8'hFF : 8'h5A, !CHK, CHK));

        trst_n = 1'b0;
        sel_a = 0; sel_b = 0; cap_i = 0; sh_i = 0; up_i = 0; tdi_i = 0;
        cd_a = '0; cd_b = '0;
        model_reset();
        #12;
        compare_model();
        @(negedge tck);
        trst_n = 1'b1;

        foreach (tbl[i]) begin
            step(0, tbl[i].sel, tbl[i].cap, tbl[i].sh, tbl[i].up, tbl[i].tdi, 32'h0, tbl[i].cd);
            chk($sformatf("tbl[%0d].tdo", i), 64'(tdo_b), 64'(tbl[i].e_tdo));
            chk($sformatf("tbl[%0d].update_data", i), 64'(ud_b), 64'(tbl[i].e_ud));
            chk($sformatf("tbl[%0d].update_strobe", i), 64'(us_b), 64'(tbl[i].e_us));
            chk($sformatf("tbl[%0d].len_error", i), 64'(le_b), 64'(tbl[i].e_le));
        end

        // ID register: capture then 32 shifts of 0 stream the constant out LSB-first.
        id_seen = '0;
        step(1, 0, 1, 0, 0, 0, 32'h0, 8'h0);
        id_seen[0] = tdo_a;
        for (int i = 1; i < 32; i++) begin
            step(1, 0, 0, 1, 0, 0, 32'h0, 8'h0);
            id_seen[i] = tdo_a;
        end
        chk("id.stream", 64'(id_seen), 64'(ID_VAL));
        step(1, 0, 0, 1, 0, 0, 32'h0, 8'h0);
        chk("id.tdo_after_32", 64'(tdo_a), 64'h0);
        step(1, 0, 0, 0, 1, 0, 32'h0, 8'h0);
        chk("id.update_zero", 64'(ud_a), 64'h0);
        chk("id.update_strobe", 64'(us_a), 64'h1);

        // Reset in the middle of a shift.
        step(0, 1, 1, 0, 0, 0, 32'h0, 8'hA5);
        for (int i = 0; i < 4; i++)
            step(0, 1, 0, 1, 0, 0, 32'h0, 8'h00);
        @(negedge tck);
        sel_b = 0; cap_i = 0; sh_i = 0; up_i = 0;
        trst_n = 1'b0;
        #1;
        model_reset();
        chk("rst.tdo", 64'(tdo_b), 64'h1);
        chk("rst.update_data", 64'(ud_b), 64'(RV_B));
        chk("rst.update_strobe", 64'(us_b), 64'h0);
        chk("rst.len_error", 64'(le_b), 64'h0);
        @(negedge tck);
        trst_n = 1'b1;
        step(0, 1, 0, 0, 1, 0, 32'h0, 8'h00);
        chk("rst.up_len_error", 64'(le_b), 64'(CHK));
        chk("rst.up_strobe", 64'(us_b), 64'(!CHK));
        chk("rst.up_data", 64'(ud_b), 64'(RV_B));

        // Random traffic against the model.
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 4) == 0, 1'($urandom),
                 32'($urandom), 8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
